// File: rtl/datapath_control_unit.sv
// datapath_control_unit: hardwired Moore sequencer for the DataPath with memory handshake, timeout fault and stop/halt.
// Define CU_INSTR_COUNT_EN to enable the retired-instruction counter on instr_count.
module datapath_control_unit #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             stop,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic [4:0]       opcode,
    output logic             run,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef struct packed {
        logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin;
        logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    } strb_t;

    state_t     r_state, w_next;
    strb_t      r_strb, w_strb;
    logic [4:0] r_op, w_op, r_opcode, w_opcode;
    logic [7:0] r_wait;
    logic       r_run, r_fault;
    logic       w_ld, w_st, w_imm, w_alu, w_halt, w_nop, w_mem, w_tmo, w_retire, w_unused;

    assign w_unused = ^ir[26:0];
    // The opcode is captured on the T2->T3 edge; ir is looked at directly only while in T2.
    assign w_op     = (r_state == T2) ? ir[31:27] : r_op;
    assign w_ld     = (w_op == 5'b00000);
    assign w_st     = (w_op == 5'b00010);
    assign w_imm    = w_ld || w_st || (w_op == 5'b00001) || (w_op == 5'b01100);
    assign w_alu    = (w_op >= 5'b00011) && (w_op <= 5'b00110);
    assign w_halt   = (w_op == 5'b11011);
    assign w_nop    = !(w_imm || w_alu || w_halt);
    assign w_mem    = (r_state == T1) || (r_state == T6 && w_ld) || (r_state == T7 && w_st);
    assign w_tmo    = w_mem && !mem_ready && (r_wait == 8'(WAIT_LIMIT - 1));
    assign w_retire = (r_state == T3 && w_nop) || (r_state == T5 && !(w_ld || w_st)) ||
                      (r_state == T7 && (w_ld || mem_ready));

    always_comb begin
        w_next = r_state;
        case (r_state)
            RST:     w_next = T0;
            T0:      w_next = T1;
            T1:      w_next = mem_ready ? T2 : (w_tmo ? HALT : T1);
            T2:      w_next = T3;
            T3:      w_next = w_halt ? HALT : T4;
            T4:      w_next = T5;
            T5:      w_next = T6;
            T6:      w_next = (w_st || mem_ready) ? T7 : (w_tmo ? HALT : T6);
            T7:      w_next = w_tmo ? HALT : T7;
            default: w_next = HALT;
        endcase
        if (w_retire) w_next = stop ? HALT : T0;
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        w_strb   = '0;
        w_opcode = '0;
        case (w_next)
            T0: {w_strb.PCout, w_strb.MARin, w_strb.IncPC, w_strb.ZLowIn} = 4'hF;
            T1: {w_strb.Zlowout, w_strb.PCin, w_strb.Read, w_strb.MDRin} = 4'hF;
            T2: {w_strb.MDRout, w_strb.IRin} = 2'b11;
            T3: begin
                w_strb.Grb   = w_imm || w_alu;
                w_strb.Yin   = w_imm || w_alu;
                w_strb.BAout = w_imm;
                w_strb.Rout  = w_alu;
            end
            T4: begin
                w_strb.ZLowIn = w_imm || w_alu;
                w_strb.Cout   = w_imm;
                w_strb.Grc    = w_alu;
                w_strb.Rout   = w_alu;
                w_opcode      = w_imm ? 5'b00011 : (w_alu ? w_op : 5'b00000);
            end
            T5: begin
                w_strb.Zlowout = 1'b1;
                w_strb.MARin   = w_ld || w_st;
                w_strb.Gra     = !(w_ld || w_st);
                w_strb.Rin     = !(w_ld || w_st);
            end
            T6: begin
                w_strb.MDRin = 1'b1;
                w_strb.Read  = w_ld;
                w_strb.Gra   = !w_ld;
                w_strb.Rout  = !w_ld;
            end
            T7: begin
                w_strb.MDRout = w_ld;
                w_strb.Gra    = w_ld;
                w_strb.Rin    = w_ld;
                w_strb.Write  = !w_ld;
            end
            default: w_strb = '0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state  <= RST;
            r_op     <= '0;
            r_wait   <= '0;
            r_strb   <= '0;
            r_opcode <= '0;
            r_run    <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_op     <= w_op;
            r_wait   <= (w_next == r_state) ? r_wait + 8'd1 : 8'd0;
            r_strb   <= w_strb;
            r_opcode <= w_opcode;
            r_run    <= (w_next != HALT) && (w_next != RST);
            r_fault  <= r_fault || w_tmo;
        end
    end

    assign {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin,
            IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout} = r_strb;
    assign opcode = r_opcode;
    assign run    = r_run;
    assign fault  = r_fault;

`ifdef CU_INSTR_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_cnt <= '0;
        else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign instr_count = r_cnt;
`else
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_datapath_control_unit.sv
// tb_datapath_control_unit: scoreboard bench for datapath_control_unit; per-cycle expected outputs come from a table of the strobe map.
module tb_datapath_control_unit;
    localparam int WL = 4;
    localparam int S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5, S_T5 = 6, S_T6 = 7, S_T7 = 8, S_H = 9;

    typedef struct packed {
        logic pcout, zhighout, zlowout, mdrout, marin, pcin, mdrin, irin, yin, zhighin, zlowin, hiin, loin;
        logic incpc, read, write, gra, grb, grc, rin, rout, baout, cout;
        logic [4:0] opc;
        logic run, fault;
    } obs_t;

    logic        clock, clear, mem_ready, stop;
    logic [31:0] ir;
    logic        PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin;
    logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, run, fault;
    logic [4:0]  opcode;
    logic [31:0] instr_count;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_ret = 0;
    obs_t sb[$];

    datapath_control_unit #(.WAIT_LIMIT(WL), .CNT_W(32)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .opcode(opcode), .run(run),
        .fault(fault), .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic obs_t obs();
        return {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin,
                IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, opcode, run, fault};
    endfunction

    function automatic logic [31:0] cnt_exp();
`ifdef CU_INSTR_COUNT_EN
        return 32'(n_ret);
`else
        return 32'd0;
`endif
    endfunction

    function automatic obs_t exp_vec(input int s, input logic [4:0] op, input bit flt);
        obs_t e;
        bit   ld, st, imm, alu;
        e   = '0;
        ld  = (op == 5'd0);
        st  = (op == 5'd2);
        imm = ld || st || op == 5'd1 || op == 5'd12;
        alu = op >= 5'd3 && op <= 5'd6;
        e.run   = s >= S_T0 && s <= S_T7;
        e.fault = flt;
        case (s)
            S_T0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; end
            S_T1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
            S_T2: begin e.mdrout = 1; e.irin = 1; end
            S_T3: if (imm) begin e.grb = 1; e.baout = 1; e.yin = 1; end
                  else if (alu) begin e.grb = 1; e.rout = 1; e.yin = 1; end
            S_T4: if (imm) begin e.cout = 1; e.zlowin = 1; e.opc = 5'b00011; end
                  else if (alu) begin e.grc = 1; e.rout = 1; e.zlowin = 1; e.opc = op; end
            S_T5: if (ld || st) begin e.zlowout = 1; e.marin = 1; end
                  else begin e.zlowout = 1; e.gra = 1; e.rin = 1; end
            S_T6: if (ld) begin e.read = 1; e.mdrin = 1; end
                  else begin e.gra = 1; e.rout = 1; e.mdrin = 1; end
            S_T7: if (ld) begin e.mdrout = 1; e.gra = 1; e.rin = 1; end
                  else e.write = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic do_reset(input string nm);
        @(negedge clock);
        clear = 1'b0;
        #1;
        n_ret = 0;
        chk({nm, " reset outs"}, obs(), '0);
        chk({nm, " reset cnt"}, instr_count, '0);
        @(negedge clock);
        clear = 1'b1;
        mem_ready = 1'b1;
        stop = 1'b0;
        sb.push_back(exp_vec(S_T0, 5'd0, 1'b0));
        @(posedge clock);
        #1;
        chk({nm, " release->T0"}, obs(), sb.pop_front());
    endtask

    task automatic hold_halt(input string nm, input bit flt);
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            stop = !i[0];
            sb.push_back(exp_vec(S_H, 5'd0, flt));
            @(posedge clock);
            #1;
            chk({nm, " halt hold"}, obs(), sb.pop_front());
        end
        chk({nm, " halt cnt"}, instr_count, cnt_exp());
    endtask

    // Build the state list this instruction must walk, then drive/check it one cycle at a time.
    task automatic exec(input string nm, input logic [31:0] iv, input int t1w, input int mw, input bit stp, input int abort_st);
        int         seq[$];
        logic [4:0] op;
        bit         flt, ret, ld, st, nop;
        op  = iv[31:27];
        ld  = (op == 5'd0);
        st  = (op == 5'd2);
        nop = !(op <= 5'd6 || op == 5'd12 || op == 5'd27);
        flt = 0;
        ret = 0;
        ir  = iv;
        seq.push_back(S_T0);
        repeat (t1w < WL ? t1w + 1 : WL) seq.push_back(S_T1);
        if (t1w >= WL) begin
            seq.push_back(S_H);
            flt = 1;
        end else begin
            seq.push_back(S_T2);
            seq.push_back(S_T3);
            if (op == 5'd27) seq.push_back(S_H);
            else if (nop) ret = 1;
            else begin
                seq.push_back(S_T4);
                seq.push_back(S_T5);
                if (ld || st) begin
                    if (st) seq.push_back(S_T6);
                    repeat (mw < WL ? mw + 1 : WL) seq.push_back(ld ? S_T6 : S_T7);
                    if (mw >= WL) begin
                        seq.push_back(S_H);
                        flt = 1;
                    end else begin
                        if (ld) seq.push_back(S_T7);
                        ret = 1;
                    end
                end else ret = 1;
            end
        end
        if (ret) seq.push_back(stp ? S_H : S_T0);
        for (int i = 0; i + 1 < seq.size(); i++) begin
            if (seq[i] == S_T3) stop = stp;
            mem_ready = (seq[i+1] != seq[i]) && (seq[i+1] != S_H);
            sb.push_back(exp_vec(seq[i+1], op, flt && seq[i+1] == S_H));
            @(posedge clock);
            #1;
            chk($sformatf("%s step %0d", nm, i + 1), obs(), sb.pop_front());
            if (seq[i+1] == abort_st) begin
                do_reset({nm, " abort"});
                return;
            end
        end
        if (ret) n_ret++;
        stop = 1'b0;
        chk({nm, " cnt"}, instr_count, cnt_exp());
    endtask

    initial begin
        clear = 1'b1;
        ir = '0;
        mem_ready = 1'b1;
        stop = 1'b0;
        #1 clear = 1'b0;
        #1;
        chk("por outs", obs(), '0);
        chk("por cnt", instr_count, '0);
        @(negedge clock);
        clear = 1'b1;
        sb.push_back(exp_vec(S_T0, 5'd0, 1'b0));
        @(posedge clock);
        #1;
        chk("por->T0", obs(), sb.pop_front());

        exec("ld", 32'h0000_0000, 0, 0, 0, -1);
        exec("add", 32'h1800_0000, 2, 0, 0, -1);
        exec("st", 32'h1000_0000, 0, 1, 0, -1);
        exec("ld_wait", 32'h0000_0000, 0, 2, 0, -1);
        exec("sub", 32'h2000_0000, 0, 0, 0, -1);
        exec("and", 32'h2FFF_FFFF, 1, 0, 0, -1);
        exec("or", 32'h3000_0000, 0, 0, 0, -1);
        exec("addi", 32'h6000_0000, 0, 0, 0, -1);
        exec("ldi", 32'h0800_0000, 0, 0, 0, -1);
        exec("nop", 32'hD000_0000, 0, 0, 0, -1);
        exec("inv", 32'hF800_0000, 0, 0, 0, -1);

        exec("ldi_stop", 32'h0800_0000, 0, 0, 1, -1);
        hold_halt("ldi_stop", 1'b0);
        do_reset("ldi_stop");

        exec("halt", 32'hD800_0000, 0, 0, 0, -1);
        hold_halt("halt", 1'b0);
        do_reset("halt");

        exec("tmo_t1", 32'h1800_0000, WL, 0, 0, -1);
        hold_halt("tmo_t1", 1'b1);
        do_reset("tmo_t1");

        exec("ld_pre", 32'h0000_0000, 0, 0, 0, -1);
        exec("st_tmo", 32'h1000_0000, 0, WL, 0, -1);
        hold_halt("st_tmo", 1'b1);
        do_reset("st_tmo");

        exec("nop_pre", 32'hD000_0000, 0, 0, 0, -1);
        exec("ld_abort", 32'h0000_0000, 0, 0, 0, S_T6);
        exec("ld_post", 32'h0000_0000, 1, 1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Hardwired Moore control sequencer for the DataPath.
- Fetches, decodes IR[31:27] and steps the T-state sequence, driving every DataPath strobe that the benches currently hand-drive.
- Adds a memory ready handshake with timeout, a stop/halt mechanism, and a fault flag.
- Sits between the memory interface and the DataPath control inputs; one instruction is in flight at a time.

Parameters:
- WAIT_LIMIT, 16: maximum cycles a memory state waits for mem_ready before faulting. Range 1..255.
- CNT_W, 32: width of the instruction counter (optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset; clear=0 resets the block.
- ir  in  32  IR contents from DataPath; opcode = ir[31:27].
- mem_ready  in  1  memory completed current Read/Write; sampled at clock rise.
- stop  in  1  level request to halt after the current instruction.
- PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin  out  1 each  DataPath strobes.
- IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  DataPath strobes.
- opcode  out  5  ALU operation select.
- run  out  1  high while sequencing.
- fault  out  1  memory timeout occurred; sticky until reset.
- instr_count  out  CNT_W  retired instruction count (optional feature).

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- All outputs decode from state plus latched opcode only. Every strobe is 0 outside the listed states.
- clear=0 forces state RST immediately: all strobes 0, opcode=0, run=0, fault=0, counter 0. Reset mid-instruction abandons that instruction.
- RST advances to T0 on the first clock rise with clear=1.
- Opcode encoding:
  - ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011.
  - Any other opcode executes as nop.
- Opcode latch: latched at the T2→T3 transition; stays stable until next T2.
- T0: PCout, MARin, IncPC, ZLowIn.
- T1: Zlowout, PCin, Read, MDRin. Holds in T1 until mem_ready=1. PCin repeats harmlessly because Z is not reloaded.
- T2: MDRout, IRin.
- T3:
  - ld/ldi/st/addi: Grb, BAout, Yin.
  - add/sub/and/or: Grb, Rout, Yin.
  - nop: go to T0. halt: go to HALT.
- T4:
  - ld/ldi/st/addi: Cout, ZLowIn, opcode=00011.
  - ALU ops: Grc, Rout, ZLowIn, opcode=latched opcode.
  - opcode output is 0 in all other states.
- T5:
  - ld/st: Zlowout, MARin.
  - ldi/addi/ALU ops: Zlowout, Gra, Rin; instruction retires, go to T0.
- T6:
  - ld: Read, MDRin; holds until mem_ready.
  - st: Gra, Rout, MDRin (Read=0 selects bus).
- T7:
  - ld: MDRout, Gra, Rin; retire.
  - st: Write; holds until mem_ready, then retires.
- Instruction latency with zero wait (cycles from T0 entry to the next T0):
  - ld and st: 8 cycles.
  - ldi, addi and ALU ops: 6 cycles.
  - nop: 4 cycles.
  - Each extra wait cycle adds 1.
- Wait counter: resets on entry to each memory state (T1, ld-T6, st-T7). If mem_ready is still 0 after WAIT_LIMIT cycles in that state, the FSM goes to HALT and sets fault=1.
- stop: sampled only at retire/nop/halt boundaries. If stop=1 there, go to HALT instead of T0. Asserting stop mid-instruction never truncates it.
- HALT: all strobes 0, run=0. Exit only via clear.
- run=1 in T0..T7, 0 in RST and HALT.
- mem_ready=1 outside memory states is ignored.

Optional Feature:
- Macro: CU_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on every retire, including nop; it does not increment for halt or a faulted instruction. Wraps from 2^CNT_W-1 to 0.
- Undefined: instr_count is tied to 0 and no counter flops exist.

Test Plan:
- ld, ir=0x0000_0000, mem_ready=1 always -> states T0..T7 in 8 cycles. Cout and ZLowIn at T4 with opcode=00011; Gra, Rin, MDRout at T7; run=1 throughout.
- add, ir=0x1800_0000, 2-cycle mem_ready delay in T1 -> T1 lasts 3 cycles. T4 has Grc, Rout, opcode=00011. Retire at T5, next T0 after 8 total cycles.
- st, ir=0x1000_0000 -> Write only in T7; Rin never asserted; Gra+Rout+MDRin in T6.
- WAIT_LIMIT=4, mem_ready held 0 in T1 -> HALT after 4 T1 cycles. fault=1, run=0, all strobes 0, stays halted until clear.
- stop=1 raised at T3 of ldi -> ldi completes Rin at T5, then HALT. Invalid opcode 0xF8000000 retires as nop in 4 cycles.
- clear pulled low during T6 of ld -> all outputs 0 immediately. After release, T0 on the next rise; instr_count=0 with CU_INSTR_COUNT_EN.
